// File: rtl/tail_pkg.sv
// Shared constants and helpers for the instruction tail sequencer.
package tail_pkg;

  localparam int unsigned WORD_BYTES_DEF = 4;
  localparam int unsigned BUF_BYTES_DEF  = 16;
  localparam int unsigned CNT_W_DEF      = 5;

  localparam logic [3:0] LEN_1 = 4'b0001;
  localparam logic [3:0] LEN_2 = 4'b0010;
  localparam logic [3:0] LEN_4 = 4'b0100;
  localparam logic [3:0] LEN_8 = 4'b1000;

  // Each one-hot bit carries its own byte weight, so the terms are simply OR-ed.
  function automatic logic [3:0] len_bytes(input logic [3:0] len);
    return ({4{len[3]}} & 4'd8) | ({4{len[2]}} & 4'd4) |
           ({4{len[1]}} & 4'd2) | ({4{len[0]}} & 4'd1);
  endfunction

endpackage

// File: rtl/tail_length.sv
// Head-nibble length decoder; returns 4'b0000 for unencoded lengths.
module tail_length
  import tail_pkg::*;
(
  input  logic [3:0] ir_i,
  output logic [3:0] len_o
);

  always_comb begin
    len_o = 4'b0000;
    if (ir_i[1:0] == 2'b00 || (ir_i[3] && !ir_i[1])) begin
      len_o = LEN_1;
    end else if (ir_i == 4'b0001) begin
      len_o = LEN_2;
    end else if (ir_i == 4'b0010) begin
      len_o = LEN_4;
    end else if (ir_i == 4'b0011) begin
      len_o = LEN_8;
    end
  end

endmodule

// File: rtl/tail_sequencer.sv
// Fetch-word byte queue that presents whole variable-length instructions to decode.
module tail_sequencer
  import tail_pkg::*;
#(
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF,
  parameter int unsigned BUF_BYTES  = BUF_BYTES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [63:0]      inst_data,
  output logic [3:0]       inst_len,
  output logic             inst_illegal,
  output logic [CNT_W-1:0] occupancy
);

  localparam int unsigned QW = BUF_BYTES * 8;

  logic [QW-1:0]    q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       illegal_cnt_q, illegal_cnt_d;

  logic [3:0]       dec_len;
  logic [CNT_W-1:0] need;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] off;
  logic             pop, push;

  tail_length u_tail_length (
    .ir_i  (q_q[3:0]),
    .len_o (dec_len)
  );

  assign inst_illegal = (dec_len == 4'b0000);
  assign inst_len     = inst_illegal ? LEN_1 : dec_len;
  assign need         = CNT_W'(len_bytes(inst_len));

  assign inst_valid  = (cnt_q >= need) && !flush;
  assign fetch_ready = (cnt_q <= CNT_W'(BUF_BYTES - WORD_BYTES));
  assign occupancy   = cnt_q;

  assign pop  = inst_valid && inst_ready;
  assign push = fetch_valid && fetch_ready && !flush;

  // Bytes at and beyond the instruction length are presented as zero.
  always_comb begin
    inst_data = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (CNT_W'(b) < need) begin
        inst_data[b*8 +: 8] = q_q[b*8 +: 8];
      end
    end
  end

  always_comb begin
    q_d           = q_q;
    cnt_d         = cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    wr_idx        = cnt_q;
    off           = '0;
    if (flush) begin
      q_d   = '0;
      cnt_d = '0;
    end else begin
      if (pop) begin
        q_d    = q_q >> {need, 3'b000};
        wr_idx = cnt_q - need;
        if (inst_illegal && illegal_cnt_q != 8'hFF) begin
          illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
      end
      // The pushed word lands right after the bytes that survive this cycle's pop.
      if (push) begin
        for (int unsigned i = 0; i < BUF_BYTES; i++) begin
          off = CNT_W'(i) - wr_idx;
          if (CNT_W'(i) >= wr_idx && off < CNT_W'(WORD_BYTES)) begin
            q_d[i*8 +: 8] = 8'(fetch_data >> {off[1:0], 3'b000});
          end
        end
      end
      cnt_d = wr_idx + (push ? CNT_W'(WORD_BYTES) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q           <= '0;
      cnt_q         <= '0;
      illegal_cnt_q <= '0;
    end else begin
      q_q           <= q_d;
      cnt_q         <= cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

endmodule
